fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register for the 32-bit RISC-V pipeline. It owns the fetch program counter (PCF) and issues word fetches to instruction memory over a request/response handshake with at most one request outstanding. It applies branch/jump redirects from Execute and the hazard unit's stall and flush controls. It drives the Decode-stage inputs InstrD, PCD and PCPlus4D consumed by the datapath.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: owns PCF, issues one word fetch at a time
// over a req/ready + rvalid handshake, and applies redirect, stall and flush controls.
module fetch_stage #(
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_W-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [DATA_W-1:0] PCTargetE,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] InstrD,
  output logic [DATA_W-1:0] PCD,
  output logic [DATA_W-1:0] PCPlus4D,
  output logic              ValidD,
  output logic              FetchBusyF
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] pcf, pcf_n;
  logic [DATA_W-1:0] pend_pc, pend_pc_n;
  logic [DATA_W-1:0] hold_instr, hold_instr_n;
  logic [DATA_W-1:0] hold_pc, hold_pc_n;
  logic              kill, kill_n;
  logic              accept;
  logic              deliver;
  logic [DATA_W-1:0] deliver_instr, deliver_pc;

  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  assign imem_req   = rst && (state == S_REQ) && !StallF;
  assign imem_addr  = pcf;
  assign accept     = imem_req && imem_ready;
  assign FetchBusyF = (state != S_REQ);

  always_comb begin
    state_n       = state;
    pcf_n         = pcf;
    pend_pc_n     = pend_pc;
    kill_n        = kill;
    hold_instr_n  = hold_instr;
    hold_pc_n     = hold_pc;
    deliver       = 1'b0;
    deliver_instr = hold_instr;
    deliver_pc    = hold_pc;
    case (state)
      S_REQ: begin
        if (accept) begin
          pend_pc_n = pcf;
          pcf_n     = pc_inc(pcf);
          kill_n    = PCSrcE;
          state_n   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_n       = S_REQ;
          deliver_instr = imem_rdata;
          deliver_pc    = pend_pc;
          // A killed, redirected or flushed response is dropped outright.
          if (!kill && !PCSrcE && !FlushD) begin
            if (!StallD) begin
              deliver = 1'b1;
            end else begin
              hold_instr_n = imem_rdata;
              hold_pc_n    = pend_pc;
              state_n      = S_HOLD;
            end
          end
        end else if (PCSrcE) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (PCSrcE || FlushD) begin
          state_n = S_REQ;
        end else if (!StallD) begin
          deliver = 1'b1;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
    if (PCSrcE) pcf_n = PCTargetE & ~DATA_W'(3);
  end

  // Fetch control and IF/ID register
  always_ff @(posedge CLK) begin
    if (!rst) begin
      state      <= S_REQ;
      pcf        <= RESET_PC;
      pend_pc    <= '0;
      kill       <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
      InstrD     <= NOP_INSTR;
      PCD        <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      pend_pc    <= pend_pc_n;
      kill       <= kill_n;
      hold_instr <= hold_instr_n;
      hold_pc    <= hold_pc_n;
      if (FlushD || (!deliver && !StallD)) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (deliver) begin
        InstrD   <= deliver_instr;
        PCD      <= deliver_pc;
        PCPlus4D <= pc_inc(deliver_pc);
        ValidD   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: per-cycle vector table, directed multi-cycle sequences,
// then randomized traffic against a behavioural fetch model and a simple memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic O = 1'b0;
  localparam logic I = 1'b1;

  logic        CLK = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, FetchBusyF;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
  );

  typedef struct {
    logic        r, sf, sd, fd, pcs;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_instr, e_pcd, e_pc4;
    logic        e_valid;
  } vec_t;

  vec_t tbl[24];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic r, sf, sd, fd, pcs, input logic [31:0] tgt,
                       input logic rdy, rv, input logic [31:0] rd);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = pcs; PCTargetE = tgt;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
  endtask

  task automatic chk(input string nm, input logic e_req, input logic [31:0] e_addr,
                     input logic e_busy, input logic [31:0] ei, ep, e4, input logic ev);
    n_checks++;
    if (imem_req !== e_req || (e_req && imem_addr !== e_addr) || FetchBusyF !== e_busy ||
        InstrD !== ei || PCD !== ep || PCPlus4D !== e4 || ValidD !== ev) begin
      n_fail++;
      $display("FAIL %s: got req=%b addr=%h busy=%b instr=%h pcd=%h pc4=%h valid=%b ; want req=%b addr=%h busy=%b instr=%h pcd=%h pc4=%h valid=%b",
               nm, imem_req, imem_addr, FetchBusyF, InstrD, PCD, PCPlus4D, ValidD,
               e_req, e_addr, e_busy, ei, ep, e4, ev);
    end
  endtask

  // Behavioural model: an in-flight fetch (possibly doomed by a redirect), an optional
  // parked instruction, and the Decode-stage triple.
  logic [31:0] m_pc, m_pend, m_buf_i, m_buf_pc, m_di, m_dp, m_d4;
  logic        m_inflight, m_doomed, m_buf_v, m_dv, exp_req, exp_busy;

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_inflight = O; m_doomed = O; m_buf_v = O;
    m_buf_i = 32'h0; m_buf_pc = 32'h0;
    m_di = NOP; m_dp = 32'h0; m_d4 = 32'h0; m_dv = O;
  endtask

  task automatic model_outputs();
    exp_req  = rst && !m_inflight && !m_buf_v && !StallF;
    exp_busy = m_inflight || m_buf_v;
  endtask

  task automatic model_step();
    logic        arrive, have, drop, dlv, acc;
    logic [31:0] gi, gp;
    if (!rst) begin
      model_reset();
      return;
    end
    arrive = m_inflight && imem_rvalid;
    gi     = m_buf_v ? m_buf_i : imem_rdata;
    gp     = m_buf_v ? m_buf_pc : m_pend;
    have   = m_buf_v || (arrive && !m_doomed);
    drop   = have && (PCSrcE || FlushD);
    dlv    = have && !drop && !StallD;
    acc    = exp_req && imem_ready;
    if (FlushD || (!dlv && !StallD)) begin
      m_di = NOP; m_dp = 32'h0; m_d4 = 32'h0; m_dv = O;
    end else if (dlv) begin
      m_di = gi; m_dp = gp; m_d4 = gp + 32'd4; m_dv = I;
    end
    if (have && !drop && StallD && !m_buf_v) begin
      m_buf_v = I; m_buf_i = gi; m_buf_pc = gp;
    end else if (drop || dlv) begin
      m_buf_v = O;
    end
    if (acc) begin
      m_pend = m_pc; m_inflight = I; m_doomed = PCSrcE;
    end else if (arrive) begin
      m_inflight = O; m_doomed = O;
    end else if (PCSrcE && m_inflight) begin
      m_doomed = I;
    end
    if (PCSrcE) m_pc = {PCTargetE[31:2], 2'b00};
    else if (acc) m_pc = m_pc + 32'd4;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  logic        mem_pending;
  int          mem_cnt;
  logic [31:0] mem_addr;

  initial begin
    // rst sf sd fd pcs tgt rdy rv rd | req addr busy instr pcd pc4 valid
    tbl[0]  = '{O,O,O,O,O,32'h0,  O,O,32'h0,         O,32'h0,   O, NOP,32'h0,32'h0,O};
    tbl[1]  = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'h0,   O, NOP,32'h0,32'h0,O};
    tbl[2]  = '{I,O,O,O,O,32'h0,  O,I,32'h00500093,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[3]  = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'h4,   O, 32'h00500093,32'h0,32'h4,I};
    tbl[4]  = '{I,O,I,O,O,32'h0,  O,O,32'h0,         O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[5]  = '{I,O,I,O,O,32'h0,  O,I,32'h00A00113,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[6]  = '{I,O,I,O,O,32'h0,  O,O,32'h0,         O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[7]  = '{I,O,O,O,O,32'h0,  O,O,32'h0,         O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[8]  = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'h8,   O, 32'h00A00113,32'h4,32'h8,I};
    tbl[9]  = '{I,O,O,O,I,32'h103,O,O,32'h0,         O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[10] = '{I,O,O,O,O,32'h0,  O,I,32'hDEADBEEF,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[11] = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'h100, O, NOP,32'h0,32'h0,O};
    tbl[12] = '{I,O,O,I,O,32'h0,  O,I,32'h00300193,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[13] = '{I,O,O,O,O,32'h0,  O,O,32'h0,         I,32'h104, O, NOP,32'h0,32'h0,O};
    tbl[14] = '{I,O,O,O,I,32'h200,I,O,32'h0,         I,32'h104, O, NOP,32'h0,32'h0,O};
    tbl[15] = '{I,O,O,O,O,32'h0,  O,I,32'h11111111,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[16] = '{I,I,O,O,O,32'h0,  I,O,32'h0,         O,32'h0,   O, NOP,32'h0,32'h0,O};
    tbl[17] = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'h200, O, NOP,32'h0,32'h0,O};
    tbl[18] = '{I,O,O,O,O,32'h0,  O,I,32'h22222222,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[19] = '{I,O,O,O,O,32'h0,  O,O,32'h0,         I,32'h204, O, 32'h22222222,32'h200,32'h204,I};
    tbl[20] = '{I,O,O,O,I,32'hFFFFFFFF,O,O,32'h0,    I,32'h204, O, NOP,32'h0,32'h0,O};
    tbl[21] = '{I,O,O,O,O,32'h0,  I,O,32'h0,         I,32'hFFFFFFFC,O, NOP,32'h0,32'h0,O};
    tbl[22] = '{I,O,O,O,O,32'h0,  O,I,32'h33333333,  O,32'h0,   I, NOP,32'h0,32'h0,O};
    tbl[23] = '{I,O,O,O,O,32'h0,  O,O,32'h0,         I,32'h0,   O, 32'h33333333,32'hFFFFFFFC,32'h0,I};

    drive(O,O,O,O,O,32'h0,O,O,32'h0);
    tick();
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].r, tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].pcs, tbl[i].tgt,
            tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #2;
      chk($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_busy,
          tbl[i].e_instr, tbl[i].e_pcd, tbl[i].e_pc4, tbl[i].e_valid);
      tick();
    end

    // Memory holds off for four cycles with the fetch parked at 0x20.
    drive(I,O,O,O,I,32'h20,O,O,32'h0);
    #2; chk("redir_to_20", I, 32'h0, O, NOP, 32'h0, 32'h0, O);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(I,O,O,O,O,32'h0,O,O,32'h0);
      #2; chk($sformatf("ready_low%0d", k), I, 32'h20, O, NOP, 32'h0, 32'h0, O);
      tick();
    end
    drive(I,O,O,O,O,32'h0,I,O,32'h0);
    #2; chk("ready_high", I, 32'h20, O, NOP, 32'h0, 32'h0, O);
    tick();
    drive(I,O,O,O,O,32'h0,O,I,32'h00400213);
    #2; chk("resp_20", O, 32'h0, I, NOP, 32'h0, 32'h0, O);
    tick();
    drive(I,O,O,O,O,32'h0,O,O,32'h0);
    #2; chk("deliv_20", I, 32'h24, O, 32'h00400213, 32'h20, 32'h24, I);

    // Reset while waiting on a response that returns after release.
    drive(I,O,O,O,O,32'h0,I,O,32'h0);
    #2; chk("issue_24", I, 32'h24, O, 32'h00400213, 32'h20, 32'h24, I);
    tick();
    drive(O,O,O,O,O,32'h0,O,O,32'h0);
    #2; chk("rst_in_wait", O, 32'h0, I, NOP, 32'h0, 32'h0, O);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(I,O,O,O,O,32'h0,O,(k == 2),32'hBAD00000);
      #2; chk($sformatf("post_rst%0d", k), I, 32'h0, O, NOP, 32'h0, 32'h0, O);
      tick();
    end
    drive(I,O,O,O,O,32'h0,I,O,32'h0);
    #2; chk("first_issue", I, 32'h0, O, NOP, 32'h0, 32'h0, O);
    tick();
    drive(I,O,O,O,O,32'h0,O,I,32'h00100093);
    #2; chk("first_resp", O, 32'h0, I, NOP, 32'h0, 32'h0, O);
    tick();
    drive(I,O,O,O,O,32'h0,O,O,32'h0);
    #2; chk("first_deliv", I, 32'h4, O, 32'h00100093, 32'h0, 32'h4, I);
    tick();

    // Randomized traffic; the first cycle is a reset that aligns the model.
    model_reset();
    mem_pending = O; mem_cnt = 0; mem_addr = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      rst       = (cyc == 0) ? O : ($urandom_range(0, 99) >= 2);
      StallF    = ($urandom_range(0, 99) < 15);
      StallD    = ($urandom_range(0, 99) < 20);
      FlushD    = ($urandom_range(0, 99) < 8);
      PCSrcE    = ($urandom_range(0, 99) < 8);
      PCTargetE = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_0FFF);
      imem_rvalid = mem_pending && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? memf(mem_addr) : $urandom;
      imem_ready  = !mem_pending && ($urandom_range(0, 3) != 0);
      #2;
      model_outputs();
      if (cyc > 0) chk($sformatf("rand%0d", cyc), exp_req, m_pc, exp_busy, m_di, m_dp, m_d4, m_dv);
      model_step();
      if (imem_rvalid) mem_pending = O;
      else if (mem_pending) mem_cnt--;
      if (imem_req && imem_ready) begin
        mem_pending = I;
        mem_cnt     = $urandom_range(0, 2);
        mem_addr    = imem_addr;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
